// File: rtl/aes_dec_iter_pkg.sv
// aes_pkg: block/state types, inverse S-box and GF(2^8)
// helpers shared by the iterative AES inverse cipher.
package aes_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sub_byte(
    input logic [7:0] b
  );
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // c is one of the InvMixColumns constants 9/11/13/14
  function automatic logic [7:0] gf_mul(
    input logic [7:0] b,
    input logic [3:0] c
  );
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? b  : 8'h00) ^
           (c[1] ? x2 : 8'h00) ^
           (c[2] ? x4 : 8'h00) ^
           (c[3] ? x8 : 8'h00);
  endfunction

  function automatic int nr_for_key(input int kb);
    return (kb == 128) ? 10 :
           (kb == 192) ? 12 : 14;
  endfunction

endpackage

// File: rtl/aes_dec_iter_if.sv
// aes_dec_iter_if: block-in / block-out valid-ready bus
// between host, key store and the AES inverse cipher.
interface aes_dec_iter_if #(
  parameter int EXP_KEY_W = 1408
);
  import aes_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  block_t               cipher_text;
  logic [EXP_KEY_W-1:0] exp_key;
  logic                 out_valid;
  logic                 out_ready;
  block_t               plain_text;

  modport master (
    output in_valid, cipher_text, exp_key,
    output out_ready,
    input  in_ready, out_valid, plain_text
  );

  modport slave (
    input  in_valid, cipher_text, exp_key,
    input  out_ready,
    output in_ready, out_valid, plain_text
  );

endinterface

// File: rtl/aes_dec_iter_inv_round.sv
// aes_inv_round: one combinational AES inverse round;
// the last round skips InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  block_t st,
  input  block_t rk,
  input  logic   last,
  output block_t nxt
);

  logic [7:0] sb [16];
  logic [7:0] mx [16];

  // byte i = row + 4*col; row r comes from column (c - r) mod 4
  function automatic int isr_src(input int i);
    return (i % 4) + 4 * (((i / 4) - (i % 4)) & 3);
  endfunction

  // shift rows, substitute, add key, then mix columns
  always_comb begin
    nxt = '0;
    for (int i = 0; i < 16; i++) begin
      sb[i] = inv_sub_byte(st[127-8*isr_src(i) -: 8])
            ^ rk[127-8*i -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      mx[4*c]   = gf_mul(sb[4*c], 4'd14)
                ^ gf_mul(sb[4*c+1], 4'd11)
                ^ gf_mul(sb[4*c+2], 4'd13)
                ^ gf_mul(sb[4*c+3], 4'd9);
      mx[4*c+1] = gf_mul(sb[4*c], 4'd9)
                ^ gf_mul(sb[4*c+1], 4'd14)
                ^ gf_mul(sb[4*c+2], 4'd11)
                ^ gf_mul(sb[4*c+3], 4'd13);
      mx[4*c+2] = gf_mul(sb[4*c], 4'd13)
                ^ gf_mul(sb[4*c+1], 4'd9)
                ^ gf_mul(sb[4*c+2], 4'd14)
                ^ gf_mul(sb[4*c+3], 4'd11);
      mx[4*c+3] = gf_mul(sb[4*c], 4'd11)
                ^ gf_mul(sb[4*c+1], 4'd13)
                ^ gf_mul(sb[4*c+2], 4'd9)
                ^ gf_mul(sb[4*c+3], 4'd14);
    end
    for (int i = 0; i < 16; i++) begin
      nxt[127-8*i -: 8] = last ? sb[i] : mx[i];
    end
  end

endmodule

// File: rtl/aes_dec_iter.sv
// aes_dec_iter: iterative AES-128/192/256 inverse cipher,
// one round per clock. CBC chaining: AES_DEC_CBC_MODE_EN.
module aes_dec_iter
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic          clk,
  input  logic          n_rst,
  aes_dec_iter_if.slave bus,
  output logic          busy
`ifdef AES_DEC_CBC_MODE_EN
  ,
  input  logic [127:0]  iv,
  input  logic          iv_load
`endif
);

  localparam int NR        = nr_for_key(KEY_BITS);
  localparam int EXP_KEY_W = 128 * (NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 &&
      KEY_BITS != 256) begin : g_bad_key
    $error("aes_dec_iter: KEY_BITS must be 128/192/256");
  end

  state_t               state, state_n;
  block_t               st, rk, dec_nxt;
  block_t               pt_q, chain_v;
  logic [EXP_KEY_W-1:0] key;
  logic [3:0]           rnd;
  logic                 ov_q, accept, fire_out, last;

  assign bus.in_ready   = (state == IDLE) ||
                          (state == DONE && bus.out_ready);
  assign bus.out_valid  = ov_q;
  assign bus.plain_text = pt_q;
  assign accept   = bus.in_valid && bus.in_ready;
  assign fire_out = (state == DONE) && bus.out_ready;
  assign last     = (rnd == 4'd0);
  assign busy     = (state == ROUND);
  assign rk = key[EXP_KEY_W-1-128*int'(rnd) -: 128];

  aes_inv_round u_round (
    .st   (st),
    .rk   (rk),
    .last (last),
    .nxt  (dec_nxt)
  );

  // next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_n = ROUND;
      ROUND:   if (last) state_n = DONE;
      DONE: begin
        if (bus.out_ready)
          state_n = bus.in_valid ? ROUND : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  // round datapath, key copy and output register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      st   <= '0;
      rnd  <= '0;
      key  <= '0;
      pt_q <= '0;
      ov_q <= 1'b0;
    end else begin
      if (fire_out) ov_q <= 1'b0;
      if (accept) begin
        key <= bus.exp_key;
        st  <= bus.cipher_text ^ bus.exp_key[127:0];
        rnd <= 4'(NR - 1);
      end else if (state == ROUND) begin
        if (!last) begin
          st  <= dec_nxt;
          rnd <= rnd - 4'd1;
        end else begin
          pt_q <= dec_nxt ^ chain_v;
          ov_q <= 1'b1;
        end
      end
    end
  end

`ifdef AES_DEC_CBC_MODE_EN
  block_t chain, ct_cap;

  // chain follows the IV, then each delivered ciphertext
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      chain  <= '0;
      ct_cap <= '0;
    end else begin
      if (state == IDLE && iv_load) chain <= iv;
      else if (fire_out)            chain <= ct_cap;
      if (accept) ct_cap <= bus.cipher_text;
    end
  end

  assign chain_v = chain;
`else
  assign chain_v = '0;
`endif

endmodule
